// File: rtl/icache_sa.sv
// Set-associative instruction cache with flop storage, round-robin replacement,
// multi-word line refill over a valid/ready memory port, fence.i flush and hit/miss counters.
module icache_sa #(
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  input  logic [29:0] addr,
  input  logic        flush,
  output logic        respValid,
  output logic        is_hit,
  output logic [31:0] rdata,
  output logic        memReqValid,
  input  logic        memReqReady,
  output logic [29:0] memAddr,
  input  logic        memRespValid,
  input  logic [31:0] memRdata,
  output logic [31:0] hitCount,
  output logic [31:0] missCount,
  output logic [1:0]  o_dbg_state
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic              r_valid [SETS][WAYS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [31:0]       r_data  [SETS][WAYS][LINE_WORDS];
  logic [WAY_W-1:0]  r_rr    [SETS];

  logic [OFF_W-1:0]  r_beat;
  logic              r_flush_pending;
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;
  logic [TAG_W-1:0]  r_tag_q;
  logic [IDX_W-1:0]  r_idx_q;
  logic [OFF_W-1:0]  r_off_q;
  logic [WAY_W-1:0]  r_vic;
  logic              r_vic_rr;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_W-1:0]  w_off;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic [31:0]       w_hit_word;
  logic              w_inv_found;
  logic [WAY_W-1:0]  w_inv_way;
  logic              w_flush_now;
  logic              w_lookup;
  logic              w_last_beat;
  logic              w_fill_beat;

  assign w_tag = addr[29 -: TAG_W];
  assign w_idx = addr[OFF_W +: IDX_W];
  assign w_off = addr[OFF_W-1:0];

  // Tag compare across the indexed set; the descending scan leaves the lowest invalid way.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    w_hit_word = r_data[w_idx][w_hit_way][w_off];
  end

  assign w_fill_beat = (r_state == S_FILL) && memRespValid;
  assign w_last_beat = w_fill_beat && (r_beat == OFF_W'(LINE_WORDS - 1));

  always_comb begin
    w_state_next = r_state;
    w_flush_now  = 1'b0;
    w_lookup     = 1'b0;
    respValid    = 1'b0;
    is_hit       = 1'b0;
    rdata        = '0;
    memReqValid  = 1'b0;
    memAddr      = '0;
    case (r_state)
      S_IDLE: begin
        w_flush_now = flush | r_flush_pending;
        w_lookup    = reqValid & ~w_flush_now;
        if (w_lookup && w_hit) begin
          respValid = 1'b1;
          is_hit    = 1'b1;
          rdata     = w_hit_word;
        end else if (w_lookup) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        memReqValid = 1'b1;
        memAddr     = {r_tag_q, r_idx_q, {OFF_W{1'b0}}};
        if (memReqReady) w_state_next = S_FILL;
      end
      S_FILL: begin
        if (w_last_beat) w_state_next = S_RESP;
      end
      S_RESP: begin
        respValid    = 1'b1;
        rdata        = r_data[r_idx_q][r_vic][r_off_q];
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_beat          <= '0;
      r_flush_pending <= 1'b0;
      r_hit_cnt       <= '0;
      r_miss_cnt      <= '0;
      r_tag_q         <= '0;
      r_idx_q         <= '0;
      r_off_q         <= '0;
      r_vic           <= '0;
      r_vic_rr        <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_valid[s][w] <= 1'b0;
      end
    end else begin
      r_state <= w_state_next;
      if (w_lookup && w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_lookup && !w_hit) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
        r_tag_q    <= w_tag;
        r_idx_q    <= w_idx;
        r_off_q    <= w_off;
        r_vic      <= w_inv_found ? w_inv_way : r_rr[w_idx];
        r_vic_rr   <= ~w_inv_found;
      end
      if (w_flush_now) r_flush_pending <= 1'b0;
      else if (flush && (r_state != S_IDLE)) r_flush_pending <= 1'b1;
      // Victim goes invalid for the whole fill so a partial line never hits.
      if ((r_state == S_REQ) && memReqReady) begin
        r_beat                  <= '0;
        r_valid[r_idx_q][r_vic] <= 1'b0;
      end
      if (w_fill_beat) r_beat <= r_beat + OFF_W'(1);
      if (w_last_beat) begin
        r_valid[r_idx_q][r_vic] <= 1'b1;
        if (r_vic_rr) r_rr[r_idx_q] <= (WAYS > 1) ? r_rr[r_idx_q] + WAY_W'(1) : '0;
      end
      if (w_flush_now) begin
        for (int s = 0; s < SETS; s++) begin
          r_rr[s] <= '0;
          for (int w = 0; w < WAYS; w++) r_valid[s][w] <= 1'b0;
        end
      end
    end
  end

  // Tag and data payload carry no reset; valid bits gate every use.
  always_ff @(posedge clock) begin
    if (w_fill_beat) r_data[r_idx_q][r_vic][r_beat] <= memRdata;
    if (w_last_beat) r_tag[r_idx_q][r_vic] <= r_tag_q;
  end

  assign hitCount    = r_hit_cnt;
  assign missCount   = r_miss_cnt;
  assign o_dbg_state = r_state;

endmodule
